// File: rtl/board_state_ctrl_pkg.sv
// Shared board geometry, tile index type, command opcodes and controller states
// for the minesweeper board state controller.
package ms_pkg;
  localparam int BOARD_W = 8;
  localparam int BOARD_H = 8;
  localparam int N_TILES = BOARD_W * BOARD_H;

  typedef logic [5:0] tile_t;

  localparam logic OP_STEP = 1'b0;
  localparam logic OP_FLAG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLOOD,
    ST_CHECK,
    ST_LOST,
    ST_WON
  } state_t;
endpackage

// File: rtl/board_state_ctrl_if.sv
// Command handshake between the player input logic (master) and the board
// state controller (slave). One tile command per accepted valid/ready beat.
interface board_state_ctrl_if;
  import ms_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  logic  cmd_op;
  tile_t cmd_tile;

  modport master (output cmd_valid, output cmd_op, output cmd_tile, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_tile, output cmd_ready);
endinterface

// File: rtl/board_state_ctrl_neighbour_dilate.sv
// neighbour_dilate: purely combinational 8-neighbour dilation of a board
// bitmap. A tile's output is set when any of its up to eight neighbours is
// set; the tile itself does not contribute. Neighbours beyond the board edge
// are skipped so nothing wraps across row ends.
module neighbour_dilate
  import ms_pkg::*;
(
  input  logic [N_TILES-1:0] map_in,
  output logic [N_TILES-1:0] map_out
);

  genvar gi;
  generate
    for (gi = 0; gi < N_TILES; gi++) begin : g_tile
      localparam int ROW = gi / BOARD_W;
      localparam int COL = gi % BOARD_W;
      logic hit;

      // OR together the in-board neighbours of this tile
      always_comb begin
        hit = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) &&
                (ROW + dr >= 0) && (ROW + dr < BOARD_H) &&
                (COL + dc >= 0) && (COL + dc < BOARD_W)) begin
              hit = hit | map_in[tile_t'((ROW + dr) * BOARD_W + COL + dc)];
            end
          end
        end
      end

      assign map_out[gi] = hit;
    end
  endgenerate

endmodule

// File: rtl/board_state_ctrl.sv
// board_state_ctrl: live flag/stepped bitmaps of the 8x8 board, step and
// flag-toggle commands over a valid/ready handshake, flood reveal from
// zero-tiles, and lost/won detection.
// Optional build macro FLOOD_FILL_EN: when defined, stepping a zero-tile
// enters FLOOD and reveals the connected empty region; when undefined only the
// stepped tile is revealed and the dilation logic is not built.
module board_state_ctrl
  import ms_pkg::*;
#(
  parameter int MAX_FLAGS = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 new_game,
  input  logic [N_TILES-1:0]   mine_map,
  board_state_ctrl_if.slave    cmd,
  output logic [N_TILES-1:0]   flag_map,
  output logic [N_TILES-1:0]   step_map,
  output logic [3:0]           flag_count,
  output logic                 busy,
  output logic                 game_over,
  output logic                 game_won
);

  state_t             state_reg, state_next;
  logic [N_TILES-1:0] flag_reg, flag_next;
  logic [N_TILES-1:0] step_reg, step_next;
  logic [3:0]         count_reg, count_next;

`ifdef FLOOD_FILL_EN
  logic [N_TILES-1:0] mine_halo;
  logic [N_TILES-1:0] zero_map;
  logic [N_TILES-1:0] frontier_halo;
  logic [N_TILES-1:0] grow;

  // Tiles with no adjacent mine; only these keep the flood spreading.
  neighbour_dilate u_mine_dilate (
    .map_in  (mine_map),
    .map_out (mine_halo)
  );
  assign zero_map = ~mine_halo;

  // Candidates for the next flood wave, computed from the registered map so
  // the reveal advances exactly one ring per cycle.
  neighbour_dilate u_flood_dilate (
    .map_in  (step_reg & zero_map & ~mine_map),
    .map_out (frontier_halo)
  );
  assign grow = frontier_halo & ~step_reg & ~flag_reg & ~mine_map;
`endif

  // Next-state, map and flag-counter update for the controller
  always_comb begin
    state_next = state_reg;
    flag_next  = flag_reg;
    step_next  = step_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          if (cmd.cmd_op == OP_FLAG) begin
            if (!step_reg[cmd.cmd_tile]) begin
              if (flag_reg[cmd.cmd_tile]) begin
                flag_next[cmd.cmd_tile] = 1'b0;
                count_next = count_reg - 4'd1;
              end else if (count_reg < 4'(MAX_FLAGS)) begin
                flag_next[cmd.cmd_tile] = 1'b1;
                count_next = count_reg + 4'd1;
              end
            end
          end else if (!flag_reg[cmd.cmd_tile] && !step_reg[cmd.cmd_tile]) begin
            step_next[cmd.cmd_tile] = 1'b1;
            if (mine_map[cmd.cmd_tile]) begin
              state_next = ST_LOST;
            end else begin
`ifdef FLOOD_FILL_EN
              state_next = zero_map[cmd.cmd_tile] ? ST_FLOOD : ST_CHECK;
`else
              state_next = ST_CHECK;
`endif
            end
          end
        end
      end
      ST_FLOOD: begin
`ifdef FLOOD_FILL_EN
        step_next = step_reg | grow;
        if (grow == '0) state_next = ST_CHECK;
`else
        state_next = ST_CHECK;
`endif
      end
      ST_CHECK: begin
        state_next = (&(step_reg | mine_map)) ? ST_WON : ST_IDLE;
      end
      ST_LOST, ST_WON: state_next = state_reg;
      default:         state_next = ST_IDLE;
    endcase
  end

  // State and bitmap registers; reset first, then a new game clears everything
  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      state_reg <= ST_IDLE;
      flag_reg  <= '0;
      step_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      flag_reg  <= flag_next;
      step_reg  <= step_next;
      count_reg <= count_next;
    end
  end

  assign cmd.cmd_ready = (state_reg == ST_IDLE);
  assign flag_map      = flag_reg;
  assign step_map      = step_reg;
  assign flag_count    = count_reg;
  assign busy          = (state_reg == ST_FLOOD) || (state_reg == ST_CHECK);
  assign game_over     = (state_reg == ST_LOST);
  assign game_won      = (state_reg == ST_WON);

endmodule

// File: tb/tb_board_state_ctrl.sv
// Self-checking bench for board_state_ctrl: directed scenarios with literal
// expectations plus randomized games, all compared every cycle against a
// tile-by-tile behavioural model of the board rules.
module tb_board_state_ctrl;
  import ms_pkg::*;

`ifdef FLOOD_FILL_EN
  localparam bit FLOOD_ON = 1'b1;
`else
  localparam bit FLOOD_ON = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_FLOOD = 1;
  localparam int M_CHECK = 2;
  localparam int M_LOST  = 3;
  localparam int M_WON   = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        new_game;
  logic [63:0] mine_map;
  logic [63:0] flag_map, step_map;
  logic [3:0]  flag_count;
  logic        busy, game_over, game_won;

  board_state_ctrl_if bus ();

  board_state_ctrl #(.MAX_FLAGS(10)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .new_game   (new_game),
    .mine_map   (mine_map),
    .cmd        (bus),
    .flag_map   (flag_map),
    .step_map   (step_map),
    .flag_count (flag_count),
    .busy       (busy),
    .game_over  (game_over),
    .game_won   (game_won)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_flag, m_step;
  int          m_cnt;
  int          m_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // True when no in-board neighbour of tile t holds a mine
  function automatic bit is_zero(input logic [63:0] mm, input int t);
    int r = t / 8;
    int c = t % 8;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
          if (mm[(r + dr) * 8 + c + dc]) return 1'b0;
    return 1'b1;
  endfunction

  // One flood wave: reveal each hidden, unflagged, safe tile that touches a
  // revealed safe zero-tile
  function automatic logic [63:0] flood_once(input logic [63:0] mm, input logic [63:0] st,
                                             input logic [63:0] fl);
    logic [63:0] res = st;
    for (int t = 0; t < 64; t++) begin
      if (!st[t] && !fl[t] && !mm[t]) begin
        int r = t / 8;
        int c = t % 8;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8) begin
              int n = (r + dr) * 8 + c + dc;
              if (st[n] && !mm[n] && is_zero(mm, n)) res[t] = 1'b1;
            end
      end
    end
    return res;
  endfunction

  task automatic model_update();
    int t;
    logic [63:0] nxt;
    if (!resetn || new_game) begin
      m_flag = '0; m_step = '0; m_cnt = 0; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.cmd_valid) begin
          t = int'(bus.cmd_tile);
          if (bus.cmd_op) begin
            if (!m_step[t]) begin
              if (m_flag[t]) begin m_flag[t] = 1'b0; m_cnt--; end
              else if (m_cnt < 10) begin m_flag[t] = 1'b1; m_cnt++; end
            end
          end else if (!m_flag[t] && !m_step[t]) begin
            m_step[t] = 1'b1;
            if (mine_map[t]) m_mode = M_LOST;
            else if (FLOOD_ON && is_zero(mine_map, t)) m_mode = M_FLOOD;
            else m_mode = M_CHECK;
          end
        end
        M_FLOOD: begin
          nxt = flood_once(mine_map, m_step, m_flag);
          if (nxt == m_step) m_mode = M_CHECK;
          else m_step = nxt;
        end
        M_CHECK: m_mode = ((m_step | mine_map) == '1) ? M_WON : M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("cyc_flag_map",   flag_map, m_flag);
    check("cyc_step_map",   step_map, m_step);
    check("cyc_flag_count", 64'(flag_count), 64'(m_cnt));
    check("cyc_cmd_ready",  64'(bus.cmd_ready), 64'(m_mode == M_IDLE));
    check("cyc_busy",       64'(busy), 64'(m_mode == M_FLOOD || m_mode == M_CHECK));
    check("cyc_game_over",  64'(game_over), 64'(m_mode == M_LOST));
    check("cyc_game_won",   64'(game_won), 64'(m_mode == M_WON));
  endtask

  // Advance one clock: model and DUT both act on the posedge, outputs are
  // compared on the following negedge where new inputs are then driven
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic op, input int tile);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_tile  = tile_t'(tile);
    $display("cmd %s tile %0d ready=%0d", op ? "flag" : "step", tile, bus.cmd_ready);
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic settle();
    int k = 0;
    while (!(bus.cmd_ready || game_over || game_won) && k < 200) begin
      cycle();
      k++;
    end
    if (!(bus.cmd_ready || game_over || game_won)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL settle_timeout: busy=%0d after 200 cycles, required idle/over/won", busy);
    end
  endtask

  task automatic start_game(input logic [63:0] mm);
    mine_map = mm;
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; new_game = 1'b0; mine_map = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_tile = '0;
    cycle();
    cycle();
    check("rst_flag_map", flag_map, 64'h0);
    check("rst_step_map", step_map, 64'h0);
    check("rst_flag_count", 64'(flag_count), 64'h0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    resetn = 1'b1;

    // Scenario 1: single mine in the far corner, step the opposite corner
    start_game(64'h8000_0000_0000_0000);
    send(OP_STEP, 0);
    settle();
    if (FLOOD_ON) begin
      check("s1_step_map", step_map, 64'h7FFF_FFFF_FFFF_FFFF);
      check("s1_model_step", m_step, 64'h7FFF_FFFF_FFFF_FFFF);
      check("s1_won", 64'(game_won), 64'h1);
      cycle();
      check("s1_ready_after_won", 64'(bus.cmd_ready), 64'h0);
    end else begin
      check("s1_step_map", step_map, 64'h1);
      check("s1_model_step", m_step, 64'h1);
      check("s1_won", 64'(game_won), 64'h0);
    end

    // Scenario 5: new game during the second flood cycle
    start_game(64'h8000_0000_0000_0000);
    send(OP_STEP, 0);
    cycle();
    if (FLOOD_ON) check("s5_busy_before", 64'(busy), 64'h1);
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
    check("s5_step_map", step_map, 64'h0);
    check("s5_flag_map", flag_map, 64'h0);
    check("s5_ready", 64'(bus.cmd_ready), 64'h1);

    // Scenario 2: step directly on a mine
    start_game(64'h200);
    send(OP_STEP, 9);
    check("s2_step_map", step_map, 64'h200);
    check("s2_game_over", 64'(game_over), 64'h1);
    send(OP_FLAG, 3);
    send(OP_STEP, 0);
    check("s2_flag_ignored", flag_map, 64'h0);
    check("s2_step_ignored", step_map, 64'h200);
    check("s2_ready", 64'(bus.cmd_ready), 64'h0);

    // Scenario 3: flagged tile blocks a step
    start_game(64'h0000_0100_0000_0000);
    send(OP_FLAG, 5);
    check("s3_count_1", 64'(flag_count), 64'h1);
    send(OP_STEP, 5);
    check("s3_step_blocked", step_map, 64'h0);
    check("s3_still_ready", 64'(bus.cmd_ready), 64'h1);
    send(OP_FLAG, 5);
    check("s3_count_0", 64'(flag_count), 64'h0);

    // Scenario 4: mines down column 0, no wrap from column 7
    start_game(64'h0101_0101_0101_0101);
    send(OP_STEP, 7);
    settle();
    if (FLOOD_ON) begin
      check("s4_step_map", step_map, 64'hFEFE_FEFE_FEFE_FEFE);
      check("s4_model_step", m_step, 64'hFEFE_FEFE_FEFE_FEFE);
      check("s4_won", 64'(game_won), 64'h1);
    end else begin
      check("s4_step_map", step_map, 64'h80);
      check("s4_won", 64'(game_won), 64'h0);
    end

    // Scenario 6: flag limit
    start_game(64'h0);
    for (int i = 0; i <= 10; i++) send(OP_FLAG, i);
    check("s6_count_sat", 64'(flag_count), 64'd10);
    check("s6_flag_map", flag_map, 64'h3FF);
    send(OP_FLAG, 0);
    send(OP_FLAG, 10);
    check("s6_flag_map_after", flag_map, 64'h7FE);
    check("s6_count_after", 64'(flag_count), 64'd10);

    // Randomized games against the model
    for (int g = 0; g < 20; g++) begin
      logic [63:0] mm = '0;
      int nm = $urandom_range(1, 12);
      repeat (nm) mm[$urandom_range(0, 63)] = 1'b1;
      $display("random game %0d mines=%h", g, mm);
      start_game(mm);
      for (int c = 0; c < 400; c++) begin
        int t = $urandom_range(0, 63);
        logic op = ($urandom_range(0, 2) == 0);
        if (!op && $urandom_range(0, 3) != 0)
          for (int k = 0; k < 4 && mm[t]; k++) t = $urandom_range(0, 63);
        resetn        = ($urandom_range(0, 999) != 0);
        new_game      = ($urandom_range(0, 39) == 0);
        bus.cmd_valid = ($urandom_range(0, 2) != 0);
        bus.cmd_op    = op;
        bus.cmd_tile  = tile_t'(t);
        cycle();
      end
      resetn = 1'b1; new_game = 1'b0; bus.cmd_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_state_ctrl.md
Name: board_state_ctrl

Overview:
Holds the live per-tile flag and stepped bitmaps for the 8x8 minesweeper board and feeds them to the per-tile status lookup and the renderer.
Accepts step and flag-toggle commands for one tile at a time over a valid/ready handshake. A step on a tile with no adjacent mines starts an iterative flood reveal. Detects game lost (mine stepped) and game won (every non-mine tile stepped).

Parameters:
BOARD_W, 8, columns; tile index = row*BOARD_W + col
BOARD_H, 8, rows
MAX_FLAGS, 10, maximum flags placed at once

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
new_game  in  1  synchronous clear of flags, steps and game result
mine_map  in  64  mine bitmap from the mine generator; held constant during a game
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
cmd_op  in  1  0 = step, 1 = toggle flag
cmd_tile  in  6  target tile index
flag_map  out  64  registered flag bitmap
step_map  out  64  registered stepped bitmap
flag_count  out  4  number of flags set
busy  out  1  high in FLOOD and CHECK
game_over  out  1  high in LOST
game_won  out  1  high in WON

Behaviour:
- Clock and reset: one clock, clk. resetn is synchronous, active-low, and has top priority.
- Reset values: flag_map=0, step_map=0, flag_count=0, state=IDLE, game_over=0, game_won=0, busy=0.
- new_game: has the next priority after resetn and applies in any state. Same clear as reset. Any command in that cycle is dropped.
- States: IDLE, FLOOD, CHECK, LOST, WON.
- cmd_ready = (state==IDLE). Combinational from state only, with no dependence on cmd_valid.
- Zero-tile definition: zero = ~dilate(mine_map), where dilate() sets every tile 8-adjacent to a set bit. Adjacency must not wrap across row ends or board edges.
- IDLE, flag command accepted:
  - Tile already stepped: no-op.
  - Tile flagged: clear the flag, flag_count-1.
  - Tile unflagged and flag_count<MAX_FLAGS: set the flag, flag_count+1.
  - Otherwise: no-op.
  - Updates are visible the next cycle; state stays IDLE.
- IDLE, step command accepted:
  - Tile flagged or already stepped: no-op, stay IDLE.
  - Tile is a mine: set step_map bit, go to LOST.
  - Otherwise: set step_map bit; next state is FLOOD if the tile is a zero-tile, else CHECK.
- FLOOD: each cycle, grow = dilate(step_map & zero & ~mine_map) & ~step_map & ~flag_map & ~mine_map, then step_map |= grow.
  - grow==0: go to CHECK (grow is computed on the current registered step_map).
  - Flood never unflags tiles; flagged tiles block propagation.
- CHECK: one cycle. If (step_map | mine_map) is all ones, go to WON; else go to IDLE.
- LOST and WON: absorbing until new_game or reset. Commands are not accepted there.
- Latency: non-zero safe step accepted at T, step_map updated at T+1 (CHECK), cmd_ready high again at T+2. A flood taking k growing cycles returns ready at T+k+3. Worst case is bounded at 64 FLOOD cycles.
- No combinational path from cmd_* to any map output.

Optional Feature:
FLOOD_FILL_EN.
- Defined: zero-tile steps enter FLOOD as described.
- Undefined: every safe step goes directly to CHECK and reveals only the stepped tile; the FLOOD state and dilation logic for step_map are not built.

Decomposition:
Package ms_pkg holds:
- BOARD_W, BOARD_H, N_TILES=64.
- Tile index type (6 bits).
- OP_STEP/OP_FLAG constants.
- State enum.

One sub-module, neighbour_dilate:
- Combinational, 64-bit map in, 64-bit 8-neighbour dilation out, edge-masked.
- Instantiated once for mine_map and once for the flood frontier.

Test Plan:
1. mine_map bit 63 only; step tile 0.
   - Flood reveals every tile except 63.
   - step_map=64'h7FFF_FFFF_FFFF_FFFF, then game_won=1 one cycle after FLOOD exits; cmd_ready stays 0 afterwards.
2. mine at tile 9; step tile 9.
   - Next cycle step_map=64'h200, game_over=1; further commands are not accepted.
3. Flag tile 5, then step tile 5, then flag tile 5 again.
   - flag_count goes 1 then 0.
   - The step is ignored: step_map stays 0 and state stays IDLE.
4. Mines at column 0 of every row (64'h0101_0101_0101_0101); step tile 7.
   - No wrap propagation.
   - Final step_map=64'hFEFE_FEFE_FEFE_FEFE and game_won=1.
5. Assert new_game during the second FLOOD cycle of scenario 1.
   - Next cycle: step_map=0, flag_map=0, state IDLE, cmd_ready=1.
6. MAX_FLAGS=10: flag tiles 0..10.
   - flag_count saturates at 10 and bit 10 of flag_map stays 0.
   - Unflagging tile 0 and then flagging tile 10 succeeds.
